// File: rtl/jk_ff_bank_if.sv
// jk_ff_bank_if: signal bundle for the jk_ff_bank register bank.
//
// Purpose : groups the control/data inputs and registered outputs of the bank
//           so a controller and the bank connect through one port.
// Modports: master - drives en/mode/j/k/load/load_data/err_clr, observes outputs
//           slave  - the bank itself; drives q/qb/sr_err/chg (and chg_cnt)
// Macro   : JK_FF_BANK_CHG_CNT_EN adds chg_cnt [CNT_W-1:0] to both modports.

interface jk_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             sr_err;
    logic             chg;

    if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1) begin : g_bad_param
        $error("jk_ff_bank_if: WIDTH must be 1..32 and CNT_W at least 1");
    end

`ifdef JK_FF_BANK_CHG_CNT_EN
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output en, mode, j, k, load, load_data, err_clr,
        input  q, qb, sr_err, chg, chg_cnt
    );

    modport slave (
        input  en, mode, j, k, load, load_data, err_clr,
        output q, qb, sr_err, chg, chg_cnt
    );
`else
    modport master (
        output en, mode, j, k, load, load_data, err_clr,
        input  q, qb, sr_err, chg
    );

    modport slave (
        input  en, mode, j, k, load, load_data, err_clr,
        output q, qb, sr_err, chg
    );
`endif

endinterface

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: WIDTH-bit edge-triggered flag register bank with run-time
// selectable JK / SR / D / T semantics, parallel load, sticky illegal-SR
// flag and a one-cycle change-detect pulse.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (beats load, en and err_clr)
//   bus  - jk_ff_bank_if.slave
//          en, mode(00 JK/01 SR/10 D/11 T), j, k, load, load_data, err_clr in
//          q, qb (always ~q), sr_err (sticky), chg (pulse) out
// Macro:
//   JK_FF_BANK_CHG_CNT_EN - adds bus.chg_cnt, a saturating count of chg pulses.
//
// Every output is a flop; there is no combinational input-to-output path.

module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    jk_ff_bank_if.slave  bus
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1) begin : g_bad_param
        $error("jk_ff_bank: WIDTH must be 1..32 and CNT_W at least 1");
    end

    logic [WIDTH-1:0] q_next;
    logic             err_set;

    always_comb begin
        q_next  = bus.q;
        err_set = 1'b0;
        if (bus.load) begin
            q_next = bus.load_data;
        end else if (bus.en) begin
            case (bus.mode)
                // Characteristic equation q+ = J~q | ~Kq covers hold/clear/set/toggle.
                MODE_JK: q_next = (bus.j & ~bus.q) | (~bus.k & bus.q);
                // S=R=1 is treated as hold: only bits where S and R differ move.
                MODE_SR: begin
                    q_next  = (bus.j & ~bus.k) | (bus.q & ~(bus.j ^ bus.k));
                    err_set = |(bus.j & bus.k);
                end
                MODE_D:  q_next = bus.j;
                MODE_T:  q_next = bus.q ^ bus.j;
                default: q_next = bus.q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.q      <= RST_VAL;
            bus.qb     <= ~RST_VAL;
            bus.sr_err <= 1'b0;
            bus.chg    <= 1'b0;
        end else begin
            bus.q      <= q_next;
            bus.qb     <= ~q_next;
            bus.chg    <= (q_next != bus.q);
            // A new illegal pattern wins over a simultaneous clear.
            bus.sr_err <= err_set | (bus.sr_err & ~bus.err_clr);
        end
    end

`ifdef JK_FF_BANK_CHG_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.chg_cnt <= '0;
        end else if (bus.chg && (bus.chg_cnt != {CNT_W{1'b1}})) begin
            bus.chg_cnt <= bus.chg_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_ff_bank.sv
module tb_jk_ff_bank;

    localparam int         W     = 4;
    localparam int         CW    = 2;
    localparam logic [3:0] RSTV  = 4'b0101;

    logic clk;
    logic rst;

    jk_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    jk_ff_bank #(.WIDTH(W), .RST_VAL(RSTV), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       sr_err;
        logic       chg;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [3:0] m_q;
    logic       m_err;
    logic       m_chg;
    logic [1:0] m_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_one();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: observed 0 entries, expected 1");
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        assert (bus.q === e.q) else begin
            n_bad++;
            $error("FAIL %s q: observed %b expected %b", e.tag, bus.q, e.q);
        end
        n_cmp++;
        assert (bus.qb === ~e.q) else begin
            n_bad++;
            $error("FAIL %s qb: observed %b expected %b", e.tag, bus.qb, ~e.q);
        end
        n_cmp++;
        assert (bus.sr_err === e.sr_err) else begin
            n_bad++;
            $error("FAIL %s sr_err: observed %b expected %b", e.tag, bus.sr_err, e.sr_err);
        end
        n_cmp++;
        assert (bus.chg === e.chg) else begin
            n_bad++;
            $error("FAIL %s chg: observed %b expected %b", e.tag, bus.chg, e.chg);
        end
`ifdef JK_FF_BANK_CHG_CNT_EN
        n_cmp++;
        assert (bus.chg_cnt === e.cnt) else begin
            n_bad++;
            $error("FAIL %s chg_cnt: observed %0d expected %0d", e.tag, bus.chg_cnt, e.cnt);
        end
`endif
    endtask

    // Drive one edge worth of stimulus, predict the outcome, then check it.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic [1:0] mode, input logic [3:0] j,
                        input logic [3:0] k, input logic ld,
                        input logic [3:0] ld_data, input logic clr);
        exp_t       e;
        logic [3:0] nq;
        logic       illegal;
        rst           = r;
        bus.en        = en;
        bus.mode      = mode;
        bus.j         = j;
        bus.k         = k;
        bus.load      = ld;
        bus.load_data = ld_data;
        bus.err_clr   = clr;

        if (r) begin
            e.q      = RSTV;
            e.sr_err = 1'b0;
            e.chg    = 1'b0;
            e.cnt    = 2'd0;
        end else begin
            nq      = m_q;
            illegal = 1'b0;
            for (int i = 0; i < W; i++) begin
                case (mode)
                    2'b00: begin
                        if (j[i] && k[i])       nq[i] = ~m_q[i];
                        else if (j[i])          nq[i] = 1'b1;
                        else if (k[i])          nq[i] = 1'b0;
                    end
                    2'b01: begin
                        if (j[i] && k[i])       illegal = 1'b1;
                        else if (j[i])          nq[i] = 1'b1;
                        else if (k[i])          nq[i] = 1'b0;
                    end
                    2'b10: nq[i] = j[i];
                    default: if (j[i]) nq[i] = ~m_q[i];
                endcase
            end
            if (ld) begin
                nq      = ld_data;
                illegal = 1'b0;
            end else if (!en) begin
                nq      = m_q;
                illegal = 1'b0;
            end
            e.q      = nq;
            e.sr_err = illegal | (m_err & ~clr);
            e.chg    = (nq != m_q);
            e.cnt    = (m_chg && m_cnt != 2'd3) ? m_cnt + 2'd1 : m_cnt;
        end
        e.tag = tag;
        sb.push_back(e);
        m_q   = e.q;
        m_err = e.sr_err;
        m_chg = e.chg;
        m_cnt = e.cnt;

        @(posedge clk);
        @(negedge clk);
        check_one();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected summary before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] rm;
        logic [3:0] rj, rk, rd;
        logic       rr, re, rl, rc;
        rst = 1'b1;
        bus.en = 1'b0; bus.mode = 2'b00; bus.j = '0; bus.k = '0;
        bus.load = 1'b0; bus.load_data = '0; bus.err_clr = 1'b0;
        m_q = 'x; m_err = 1'b0; m_chg = 1'b0; m_cnt = '0;

        //    tag               rst en mode   j        k        ld  ld_data  clr
        step("reset",           1, 0, 2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        step("rst_over_load",   1, 1, 2'b00, 4'b1111, 4'b1111, 1, 4'b1100, 1);
        step("jk_all_cases",    0, 1, 2'b00, 4'b0011, 4'b0101, 0, 4'b0000, 0);
        step("en_low_hold",     0, 0, 2'b00, 4'b1111, 4'b1111, 0, 4'b0000, 0);
        step("load_0101",       0, 0, 2'b01, 4'b0000, 4'b0000, 1, 4'b0101, 0);
        step("sr_illegal",      0, 1, 2'b01, 4'b1001, 4'b1000, 0, 4'b0000, 0);
        step("sr_set_beats_clr",0, 1, 2'b01, 4'b1001, 4'b1000, 0, 4'b0000, 1);
        step("sr_err_clear",    0, 1, 2'b01, 4'b0010, 4'b0001, 0, 4'b0000, 1);
        step("d_mode",          0, 1, 2'b10, 4'b1010, 4'b0101, 0, 4'b0000, 0);
        step("t_mode",          0, 1, 2'b11, 4'b1111, 4'b0000, 0, 4'b0000, 0);
        step("t_en_low",        0, 0, 2'b11, 4'b1111, 4'b0000, 0, 4'b0000, 0);
        step("load_over_en",    0, 1, 2'b00, 4'b1111, 4'b1111, 1, 4'b0110, 0);
        step("load_equal",      0, 1, 2'b00, 4'b1111, 4'b1111, 1, 4'b0110, 0);
        step("load_no_sr_err",  0, 1, 2'b01, 4'b1111, 4'b1111, 1, 4'b0110, 0);
        step("en_low_no_err",   0, 0, 2'b01, 4'b1111, 4'b1111, 0, 4'b0000, 0);
        step("sr_err_again",    0, 1, 2'b01, 4'b0100, 4'b0100, 0, 4'b0000, 0);
        step("sr_err_sticky",   0, 0, 2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        step("rst_mid_op",      1, 1, 2'b11, 4'b1111, 4'b0000, 0, 4'b0000, 0);
        for (int i = 0; i < 5; i++)
            step("t_toggle_cnt", 0, 1, 2'b11, 4'b1111, 4'b0000, 0, 4'b0000, 0);
        step("t_single_bit",    0, 1, 2'b11, 4'b0001, 4'b1111, 0, 4'b0000, 0);
        step("jk_hold_all",     0, 1, 2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 0);

        for (int i = 0; i < 60; i++) begin
            rr = ($urandom_range(0, 15) == 0);
            re = 1'($urandom);
            rm = 2'($urandom);
            rj = 4'($urandom);
            rk = 4'($urandom);
            rl = ($urandom_range(0, 5) == 0);
            rd = 4'($urandom);
            rc = ($urandom_range(0, 3) == 0);
            step("random", rr, re, rm, rj, rk, rl, rd, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
